// File: rtl/example_seq_ctrl.sv
// example_seq_ctrl
//   Sequencer that walks the five-state example FSM (S0..S4, 3-bit Q)
//   through S0->S1->S2->S3->S4->S0. It drives the FSM's A, B and D
//   inputs, moves to the next step once Q shows the expected state, and
//   flags an error when one step waits too long.
//
// Optional feature macro: EXAMPLE_SEQ_LOOP_EN
//   When defined, the loop_en input exists. With loop_en=1 the walk
//   restarts straight from S_DONE, so back-to-back walks run without
//   returning to IDLE.
//
// Parameters
//   TIMEOUT  most cycles a step may wait for its expected Q (>= 2)
//
// Ports
//   clk       clock, all state on the rising edge
//   rst       asynchronous active-high reset
//   start     level, begins a walk (sampled in IDLE and S_ERR only)
//   abort     level, forces IDLE on the next edge (highest priority)
//   loop_en   (EXAMPLE_SEQ_LOOP_EN only) repeat walks back-to-back
//   q_in      Q output of the driven FSM
//   drv_a     to FSM input A
//   drv_b     to FSM input B
//   drv_d     to FSM input D
//   busy      high in every state except IDLE
//   done      one-cycle pulse after a successful walk
//   err       sticky timeout flag, cleared by the next accepted start
//   err_step  step index (1..5) that timed out, 0 if none
//   step      current step index (IDLE=0 .. DONE=6, ERR=7)
module example_seq_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
`ifdef EXAMPLE_SEQ_LOOP_EN
  input  logic       loop_en,
`endif
  input  logic [2:0] q_in,
  output logic       drv_a,
  output logic       drv_b,
  output logic [3:0] drv_d,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] err_step,
  output logic [2:0] step
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // The encoding equals the externally visible step index.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A    = 3'd1,
    S_D1   = 3'd2,
    S_AB   = 3'd3,
    S_D2   = 3'd4,
    S_RET  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            r_err;
  logic            w_err_next;
  logic [2:0]      r_err_step;
  logic [2:0]      w_err_step_next;
  logic            r_done;
  logic            r_busy;
  logic            r_drv_a;
  logic            r_drv_b;
  logic [3:0]      r_drv_d;

  logic [2:0]      w_exp_q;
  logic            w_exit;
  logic            w_limit;
  logic            w_loop;

`ifdef EXAMPLE_SEQ_LOOP_EN
  assign w_loop = loop_en;
`else
  assign w_loop = 1'b0;
`endif

  // Q value that confirms the FSM reached the state this step is aiming for.
  always_comb begin
    w_exp_q = 3'b000;
    case (r_state)
      S_A:     w_exp_q = 3'b011;
      S_D1:    w_exp_q = 3'b100;
      S_AB:    w_exp_q = 3'b000;
      S_D2:    w_exp_q = 3'b111;
      S_RET:   w_exp_q = 3'b000;
      default: w_exp_q = 3'b000;
    endcase
  end

  assign w_exit  = (q_in == w_exp_q);
  // r_cnt counts edges already spent in the step, so the edge that would
  // make it TIMEOUT is the last one this step is allowed.
  assign w_limit = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_next          = r_state;
    w_cnt_next      = r_cnt;
    w_err_next      = r_err;
    w_err_step_next = r_err_step;
    if (abort) begin
      w_next     = S_IDLE;
      w_cnt_next = '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR: begin
          if (start) begin
            w_next          = S_A;
            w_cnt_next      = '0;
            w_err_next      = 1'b0;
            w_err_step_next = 3'd0;
          end
        end
        S_A, S_D1, S_AB, S_D2, S_RET: begin
          // A matching Q wins over the limit on the same edge.
          if (w_exit) begin
            w_next     = state_t'(r_state + 3'd1);
            w_cnt_next = '0;
          end else if (w_limit) begin
            w_next          = S_ERR;
            w_cnt_next      = '0;
            w_err_next      = 1'b1;
            w_err_step_next = r_state;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          w_next     = w_loop ? S_A : S_IDLE;
          w_cnt_next = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state, so they line up with step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_err_step <= 3'd0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_drv_a    <= 1'b0;
      r_drv_b    <= 1'b0;
      r_drv_d    <= 4'b0000;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_err      <= w_err_next;
      r_err_step <= w_err_step_next;
      r_done     <= (w_next == S_DONE);
      r_busy     <= (w_next != S_IDLE);
      r_drv_a    <= (w_next == S_A) || (w_next == S_AB);
      r_drv_b    <= (w_next == S_AB);
      r_drv_d    <= (w_next == S_D1) ? 4'b0100 :
                    (w_next == S_D2) ? 4'b1000 : 4'b0000;
    end
  end

  assign drv_a    = r_drv_a;
  assign drv_b    = r_drv_b;
  assign drv_d    = r_drv_d;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign err_step = r_err_step;
  assign step     = r_state;

endmodule
